trans_ingress_fifo: RTL

//  Ingress stage directly upstream of the transaction validator.

---
 rtl/trans_ingress_fifo_if.sv | 29 ++
 rtl/trans_ingress_fifo.sv | 113 +++++++++++
 2 files changed

// File: rtl/trans_ingress_fifo_if.sv
// Ingress/egress bundle for trans_ingress_fifo.
// slave  : the FIFO side (accepts beats, presents head word, counters).
// master : the upstream link plus validator side that drives beats and acks.
interface trans_ingress_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_sop;
  logic              in_ready;
  logic [127:0]      data_o;
  logic              valid_o;
  logic              ack_i;
  logic [CW-1:0]     count_o;
  logic [DROP_W-1:0] drop_cnt_o;

  modport master (
    output in_data, in_valid, in_sop, ack_i,
    input  in_ready, data_o, valid_o, count_o, drop_cnt_o
  );

  modport slave (
    input  in_data, in_valid, in_sop, ack_i,
    output in_ready, data_o, valid_o, count_o, drop_cnt_o
  );
endinterface

// File: rtl/trans_ingress_fifo.sv
// Purpose: assemble 4x32-bit beats into 128-bit transaction words and buffer them for the validator.
// Latency: head valid the cycle after the 4th beat is accepted into an empty FIFO.
// Backpressure: registered in_ready = !full; head held (level valid) until ack_i.
// Ports: clk, rst (sync, active-high); bus.slave carries in_data/in_valid/in_sop/in_ready
//        on the ingress side and data_o/valid_o/ack_i/count_o/drop_cnt_o on the egress side.
module trans_ingress_fifo #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  trans_ingress_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [127:0]      mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        bidx_q, bidx_d;
  // Beats 0..2 of the transaction under assembly, i.e. word bits [127:32].
  logic [95:0]       buf_q, buf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              valid_q, valid_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              pop;
  logic              push;
  logic              drop_evt;
  logic [127:0]      wr_dat;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    pop      = bus.ack_i & valid_q;
    push     = 1'b0;
    drop_evt = 1'b0;
    wr_dat   = {buf_q, bus.in_data};
    bidx_d   = bidx_q;
    buf_d    = buf_q;
    drop_d   = drop_q;

    if (accept) begin
      if (bus.in_sop) begin
        // A new sop always restarts assembly; any partial in flight is lost.
        drop_evt      = (bidx_q != 2'd0);
        buf_d[95:64]  = bus.in_data;
        bidx_d        = 2'd1;
      end else begin
        case (bidx_q)
          2'd0: drop_evt = 1'b1;  // orphan beat, no sop seen
          2'd1: begin buf_d[63:32] = bus.in_data; bidx_d = 2'd2; end
          2'd2: begin buf_d[31:0]  = bus.in_data; bidx_d = 2'd3; end
          default: begin push = 1'b1; bidx_d = 2'd0; end
        endcase
      end
    end

    if (drop_evt && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Both flags look at the next count so they line up with count_q.
    valid_d    = (count_d != '0);
    in_ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bidx_q     <= '0;
      buf_q      <= '0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bidx_q     <= bidx_d;
      buf_q      <= buf_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= wr_dat;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.count_o    = count_q;
  assign bus.drop_cnt_o = drop_q;
endmodule
